// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM states,
// byte-enable and access-legality helpers.
package mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_t;

   function automatic logic [3:0] be_from_funct3(logic [2:0] funct3, logic [1:0] addr_lo);
      logic [3:0] be;
      case (funct3)
         F3_B, F3_BU: be = 4'b0001 << addr_lo;
         F3_H, F3_HU: be = addr_lo[1] ? 4'b1100 : 4'b0011;
         F3_W:        be = 4'b1111;
         default:     be = 4'b0000;
      endcase
      return be;
   endfunction

   // Unsigned widths are loads only; the rest fail on misalignment or bad code.
   function automatic logic access_err(logic we, logic [2:0] funct3, logic [1:0] addr_lo);
      logic err;
      case (funct3)
         F3_B:    err = 1'b0;
         F3_BU:   err = we;
         F3_H:    err = addr_lo[0];
         F3_HU:   err = we | addr_lo[0];
         F3_W:    err = (addr_lo != 2'b00);
         default: err = 1'b1;
      endcase
      return err;
   endfunction

endpackage

// File: rtl/load_align.sv
// Selects the byte/half lane of a little-endian word and sign- or zero-extends
// it according to the RV32I load funct3.
module load_align
   import mem_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] word,
   input  logic [1:0]       addr_lo,
   input  logic [2:0]       funct3,
   output logic [WIDTH-1:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word[{addr_lo, 3'b000} +: 8];
      half_sel = addr_lo[1] ? word[31:16] : word[15:0];
      case (funct3)
         F3_B:    data = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
         F3_BU:   data = {{(WIDTH-8){1'b0}}, byte_sel};
         F3_H:    data = {{(WIDTH-16){half_sel[15]}}, half_sel};
         F3_HU:   data = {{(WIDTH-16){1'b0}}, half_sel};
         F3_W:    data = word;
         default: data = '0;
      endcase
   end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one outstanding load/store over valid/ready, stores
// commit at acceptance, responses appear after a programmable latency.
module data_mem_responder
   import mem_pkg::*;
#(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned ADDR_WIDTH = 17,
   parameter int unsigned LATENCY    = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [2:0]       req_funct3,
   input  logic [WIDTH-1:0] req_addr,
   input  logic [WIDTH-1:0] req_wdata,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_rdata,
   output logic             rsp_err
);

   localparam int unsigned DEPTH = 2 ** (ADDR_WIDTH - 2);

   logic [WIDTH-1:0] mem [DEPTH];

   mem_state_t       state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic             err_q, err_d;

   logic [ADDR_WIDTH-3:0] idx;
   logic [1:0]            addr_lo;
   logic                  acc_err;
   logic                  accept;
   logic [3:0]            be;
   logic [WIDTH-1:0]      wdata_rep;
   logic [WIDTH-1:0]      load_data;

   assign idx     = req_addr[ADDR_WIDTH-1:2];
   assign addr_lo = req_addr[1:0];
   assign acc_err = access_err(req_we, req_funct3, addr_lo);
   assign be      = be_from_funct3(req_funct3, addr_lo) & {4{~acc_err}};

   // Replicate the right-aligned store data so the byte enables pick the lanes.
   always_comb begin
      case (req_funct3)
         F3_B:    wdata_rep = {4{req_wdata[7:0]}};
         F3_H:    wdata_rep = {2{req_wdata[15:0]}};
         default: wdata_rep = req_wdata;
      endcase
   end

   load_align #(
      .WIDTH (WIDTH)
   ) u_load_align (
      .word    (mem[idx]),
      .addr_lo (addr_lo),
      .funct3  (req_funct3),
      .data    (load_data)
   );

   always_ff @(posedge clk) begin
      if (accept && req_we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      accept    = 1'b0;
      unique case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept  = 1'b1;
               err_d   = acc_err;
               rdata_d = (acc_err || req_we) ? '0 : load_data;
               if (LATENCY == 1) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = 4'(LATENCY - 1);
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) state_d = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (LATENCY = 2).
module tb_data_mem_responder;

   localparam int unsigned LAT = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int checks = 0;
   int errors = 0;

   data_mem_responder #(
      .WIDTH      (32),
      .ADDR_WIDTH (17),
      .LATENCY    (LAT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err)
   );

   always #5 clk = ~clk;

   // Issue one request; lat counts cycles from the acceptance cycle to rsp_valid.
   task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata,
                       output logic err, output int lat);
      int n;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
      if (n >= 20) lat = 99;
      rdata = rsp_rdata;
      err   = rsp_err;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks += 4;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
      if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rsp_rdata); end
      if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", rsp_err); end
      rst = 1'b1;
   endtask

   task automatic test_word();
      logic [31:0] d; logic e; int l;
      xact(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, d, e, l);
      checks += 3;
      if (l != LAT) begin errors++; $display("FAIL sw_latency got %0d want %0d", l, LAT); end
      if (d !== 32'h0) begin errors++; $display("FAIL sw_rdata got %h want 0", d); end
      if (e !== 1'b0) begin errors++; $display("FAIL sw_err got %b want 0", e); end
      xact(1'b0, 3'b010, 32'h100, 32'h0, d, e, l);
      checks += 3;
      if (l != LAT) begin errors++; $display("FAIL lw_latency got %0d want %0d", l, LAT); end
      if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata got %h want deadbeef", d); end
      if (e !== 1'b0) begin errors++; $display("FAIL lw_err got %b want 0", e); end
   endtask

   task automatic test_subword_loads();
      logic [31:0] d; logic e; int l;
      logic [2:0]  f3  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
      logic [31:0] ad  [4] = '{32'h103, 32'h103, 32'h102, 32'h100};
      logic [31:0] exp [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
      for (int i = 0; i < 4; i++) begin
         xact(1'b0, f3[i], ad[i], 32'h0, d, e, l);
         checks += 2;
         if (d !== exp[i]) begin
            errors++; $display("FAIL subword_load[%0d] got %h want %h", i, d, exp[i]);
         end
         if (e !== 1'b0) begin errors++; $display("FAIL subword_err[%0d] got %b want 0", i, e); end
      end
   endtask

   task automatic test_store_lanes();
      logic [31:0] d; logic e; int l;
      xact(1'b1, 3'b000, 32'h101, 32'hFFFFFF5A, d, e, l);
      xact(1'b0, 3'b010, 32'h100, 32'h0, d, e, l);
      checks++;
      if (d !== 32'hDEAD5AEF) begin errors++; $display("FAIL sb_lane got %h want dead5aef", d); end
      xact(1'b1, 3'b001, 32'h102, 32'hABCD1234, d, e, l);
      xact(1'b0, 3'b010, 32'h100, 32'h0, d, e, l);
      checks++;
      if (d !== 32'h12345AEF) begin errors++; $display("FAIL sh_lane got %h want 12345aef", d); end
      // Bits above ADDR_WIDTH are dropped, so this aliases 0x100.
      xact(1'b0, 3'b010, 32'h0002_0100, 32'h0, d, e, l);
      checks++;
      if (d !== 32'h12345AEF) begin errors++; $display("FAIL addr_wrap got %h want 12345aef", d); end
   endtask

   task automatic test_errors();
      logic [31:0] d; logic e; int l;
      xact(1'b0, 3'b010, 32'h102, 32'h0, d, e, l);
      checks += 2;
      if (e !== 1'b1) begin errors++; $display("FAIL lw_misaligned_err got %b want 1", e); end
      if (d !== 32'h0) begin errors++; $display("FAIL lw_misaligned_rdata got %h want 0", d); end
      xact(1'b1, 3'b001, 32'h101, 32'h0000FFFF, d, e, l);
      checks++;
      if (e !== 1'b1) begin errors++; $display("FAIL sh_misaligned_err got %b want 1", e); end
      xact(1'b1, 3'b100, 32'h100, 32'h000000FF, d, e, l);
      checks++;
      if (e !== 1'b1) begin errors++; $display("FAIL sbu_illegal_err got %b want 1", e); end
      xact(1'b0, 3'b011, 32'h100, 32'h0, d, e, l);
      checks += 2;
      if (e !== 1'b1) begin errors++; $display("FAIL f3_011_err got %b want 1", e); end
      if (d !== 32'h0) begin errors++; $display("FAIL f3_011_rdata got %h want 0", d); end
      xact(1'b0, 3'b010, 32'h100, 32'h0, d, e, l);
      checks += 2;
      if (d !== 32'h12345AEF) begin errors++; $display("FAIL mem_unchanged got %h want 12345aef", d); end
      if (e !== 1'b0) begin errors++; $display("FAIL mem_unchanged_err got %b want 0", e); end
   endtask

   task automatic test_backpressure();
      logic [31:0] d; int n;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
      @(negedge clk);
      // Second request held pending while the first response is stalled.
      req_funct3 = 3'b100;
      n = 0;
      while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (n >= 20) begin errors++; $display("FAIL bp_rsp_timeout got no rsp_valid want 1"); end
      for (int i = 0; i < 5; i++) begin
         checks += 3;
         if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b want 1", i, rsp_valid); end
         if (rsp_rdata !== 32'h12345AEF) begin
            errors++; $display("FAIL bp_rdata[%0d] got %h want 12345aef", i, rsp_rdata);
         end
         if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got %b want 0", i, req_ready); end
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      checks++;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after got %b want 1", req_ready); end
      @(negedge clk);
      req_valid = 1'b0;
      n = 1;
      while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
      d = rsp_rdata;
      checks += 2;
      if (n != LAT) begin errors++; $display("FAIL bp_second_latency got %0d want %0d", n, LAT); end
      if (d !== 32'h000000EF) begin errors++; $display("FAIL bp_second_rdata got %h want 000000ef", d); end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [31:0] d; logic e; int l;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
      req_addr = 32'h204; req_wdata = 32'hCAFEF00D;
      @(negedge clk);
      req_valid = 1'b0; req_we = 1'b0;
      rst = 1'b0;
      #1;
      checks += 2;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", rsp_valid); end
      if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", req_ready); end
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_dropped[%0d] got %b want 0", i, rsp_valid); end
      end
      xact(1'b0, 3'b010, 32'h204, 32'h0, d, e, l);
      checks++;
      if (d !== 32'hCAFEF00D) begin errors++; $display("FAIL midrst_store_kept got %h want cafef00d", d); end
   endtask

   initial begin
      test_reset();
      test_word();
      test_subword_loads();
      test_store_lanes();
      test_errors();
      test_backpressure();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
